// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the pipeline's fetch/data ports and the memory side.
// The slave modport is the arbiter's view; master is the pipeline-plus-memory view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, m_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata, m_be, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store:
// data-first priority with a fetch anti-starvation counter, one transaction at a time.
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// ISSUE | m_en strobe for the latched transaction
// WAIT  | read latency countdown; capture m_rdata at zero
// DONE  | ready pulse to the winning port
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic        gnt_data_q, gnt_data_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_data  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          // Fetch overrides data only once the starvation count has reached its limit.
          pick_data  = bus.d_req && !(bus.if_req && (starve_q == STARVE_LIM));
          gnt_data_d = pick_data;
          state_d    = ISSUE;
          if (pick_data) begin
            we_d    = bus.d_we;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            be_d    = bus.d_be;
            if (!bus.if_req)
              starve_d = '0;
            else if (starve_q != STARVE_LIM)
              starve_d = starve_q + 4'd1;
          end else begin
            we_d     = 1'b0;
            addr_d   = bus.if_addr;
            be_d     = 4'hF;
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          lat_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 3'd0) begin
          if (gnt_data_q) d_rdata_d  = bus.m_rdata;
          else            if_rdata_d = bus.m_rdata;
          state_d = DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_en     = (state_q == ISSUE);
  assign bus.m_we     = (state_q == ISSUE) && we_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.m_be     = be_q;
  assign bus.if_ready = (state_q == DONE) && !gnt_data_q;
  assign bus.d_ready  = (state_q == DONE) && gnt_data_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at MEM_LAT=1 for the main scenarios,
// a second at MEM_LAT=4 for reset during a read wait.
module tb_mem_arbiter;

  localparam logic [31:0] GARB = 32'hCAFE_0BAD;

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst4;
  int vectors = 0;
  int miscompares = 0;
  exp_t exp_q[$];

  mem_arbiter_if b1();
  mem_arbiter_if b4();

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_arbiter #(.MEM_LAT(4), .STARVE_MAX(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [136:0] outs1();
    return {b1.if_rdata, b1.if_ready, b1.d_rdata, b1.d_ready, b1.m_en, b1.m_we,
            b1.m_addr, b1.m_wdata, b1.m_be, b1.busy};
  endfunction

  function automatic logic [136:0] outs4();
    return {b4.if_rdata, b4.if_ready, b4.d_rdata, b4.d_ready, b4.m_en, b4.m_we,
            b4.m_addr, b4.m_wdata, b4.m_be, b4.busy};
  endfunction

  // Memory models: read data is valid only in the cycle MEM_LAT after the m_en cycle.
  int left1 = 0, left4 = 0;
  logic [31:0] pa1, pa4;
  always @(negedge clk) begin
    if (b1.m_en && !b1.m_we) begin
      left1 = 1; pa1 = b1.m_addr; b1.m_rdata = GARB;
    end else if (left1 > 0) begin
      left1--; b1.m_rdata = (left1 == 0) ? mem_f(pa1) : GARB;
    end else b1.m_rdata = GARB;
    if (b4.m_en && !b4.m_we) begin
      left4 = 4; pa4 = b4.m_addr; b4.m_rdata = GARB;
    end else if (left4 > 0) begin
      left4--; b4.m_rdata = (left4 == 0) ? mem_f(pa4) : GARB;
    end else b4.m_rdata = GARB;
  end

  task automatic clear_inputs();
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0;
    b1.d_addr = '0; b1.d_wdata = '0; b1.d_be = '0;
    b4.if_req = 0; b4.if_addr = '0; b4.d_req = 0; b4.d_we = 0;
    b4.d_addr = '0; b4.d_wdata = '0; b4.d_be = '0;
  endtask

  task automatic test_reset();
    logic [136:0] o;
    rst1 = 1; rst4 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b1.if_req = 1'($urandom); b1.if_addr = $urandom; b1.d_req = 1'($urandom);
      b1.d_we = 1'($urandom); b1.d_addr = $urandom; b1.d_wdata = $urandom;
      b1.d_be = 4'($urandom);
      o = outs1(); vectors++;
      if (o !== '0) begin
        miscompares++; $display("FAIL reset_hold1 got=%h want=0", o);
      end
      o = outs4(); vectors++;
      if (o !== '0) begin
        miscompares++; $display("FAIL reset_hold4 got=%h want=0", o);
      end
    end
    @(negedge clk);
    clear_inputs();
    rst1 = 0; rst4 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o = outs1(); vectors++;
      if (o !== '0) begin
        miscompares++; $display("FAIL reset_release got=%h want=0", o);
      end
    end
  endtask

  task automatic test_fetch_read();
    exp_t e;
    @(negedge clk);
    b1.if_req = 1; b1.if_addr = 32'h100;
    exp_q.push_back('{is_data: 1'b0, addr: 32'h100, rdata: 32'hDEAD_BEEF});
    @(negedge clk);
    vectors++;
    if ({b1.m_en, b1.m_we, b1.m_addr, b1.m_be, b1.busy} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b1}) begin
      miscompares++;
      $display("FAIL fetch_issue got en=%b we=%b addr=%h be=%h busy=%b want en=1 we=0 addr=100 be=f busy=1",
               b1.m_en, b1.m_we, b1.m_addr, b1.m_be, b1.busy);
    end
    @(negedge clk);
    vectors++;
    if ({b1.m_en, b1.if_ready, b1.if_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_wait got en=%b rdy=%b rdata=%h want 0 0 0", b1.m_en, b1.if_ready, b1.if_rdata);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    vectors++;
    if ({b1.if_ready, b1.d_ready, b1.if_rdata} !== {1'b1, 1'b0, e.rdata}) begin
      miscompares++;
      $display("FAIL fetch_ready got if_rdy=%b d_rdy=%b rdata=%h want 1 0 %h",
               b1.if_ready, b1.d_ready, b1.if_rdata, e.rdata);
    end
    b1.if_req = 0;
    @(negedge clk);
    vectors++;
    if ({b1.if_ready, b1.busy, b1.if_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL fetch_after got rdy=%b busy=%b rdata=%h want 0 0 deadbeef",
               b1.if_ready, b1.busy, b1.if_rdata);
    end
  endtask

  task automatic test_data_write();
    @(negedge clk);
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h2000; b1.d_wdata = 32'h1234_5678; b1.d_be = 4'b0011;
    @(negedge clk);
    vectors++;
    if ({b1.m_en, b1.m_we, b1.m_addr, b1.m_wdata, b1.m_be} !==
        {1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011}) begin
      miscompares++;
      $display("FAIL write_issue got en=%b we=%b addr=%h wd=%h be=%b want 1 1 2000 12345678 0011",
               b1.m_en, b1.m_we, b1.m_addr, b1.m_wdata, b1.m_be);
    end
    @(negedge clk);
    vectors++;
    if ({b1.d_ready, b1.if_ready, b1.m_en, b1.m_we, b1.d_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL write_ready got d_rdy=%b if_rdy=%b en=%b we=%b d_rdata=%h want 1 0 0 0 0",
               b1.d_ready, b1.if_ready, b1.m_en, b1.m_we, b1.d_rdata);
    end
    b1.d_req = 0; b1.d_we = 0;
    @(negedge clk);
    vectors++;
    if ({b1.d_ready, b1.busy, b1.m_addr, b1.m_be, b1.if_rdata} !==
        {1'b0, 1'b0, 32'h2000, 4'b0011, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL write_after got rdy=%b busy=%b addr=%h be=%b if_rdata=%h want 0 0 2000 0011 deadbeef",
               b1.d_ready, b1.busy, b1.m_addr, b1.m_be, b1.if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    @(negedge clk);
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h3000; b1.d_be = 4'hF;
    b1.if_req = 1; b1.if_addr = 32'h104;
    exp_q.push_back('{is_data: 1'b1, addr: 32'h3000, rdata: mem_f(32'h3000)});
    exp_q.push_back('{is_data: 1'b0, addr: 32'h104, rdata: mem_f(32'h104)});
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1 || c == 5) begin
        e = exp_q[0];
        vectors++;
        if ({b1.m_en, b1.m_addr, b1.m_we} !== {1'b1, e.addr, 1'b0}) begin
          miscompares++;
          $display("FAIL simul_issue c=%0d got en=%b addr=%h we=%b want 1 %h 0",
                   c, b1.m_en, b1.m_addr, b1.m_we, e.addr);
        end
      end else if (c == 3 || c == 7) begin
        e = exp_q.pop_front();
        vectors++;
        if ({b1.d_ready, b1.if_ready} !== {e.is_data, !e.is_data} ||
            (e.is_data ? b1.d_rdata : b1.if_rdata) !== e.rdata) begin
          miscompares++;
          $display("FAIL simul_ready c=%0d got d_rdy=%b if_rdy=%b d_rd=%h if_rd=%h want data=%b rdata=%h",
                   c, b1.d_ready, b1.if_ready, b1.d_rdata, b1.if_rdata, e.is_data, e.rdata);
        end
        if (e.is_data) b1.d_req = 0;
        else b1.if_req = 0;
      end else begin
        vectors++;
        if ({b1.m_en, b1.d_ready, b1.if_ready} !== 3'b000) begin
          miscompares++;
          $display("FAIL simul_quiet c=%0d got en=%b d_rdy=%b if_rdy=%b want 0 0 0",
                   c, b1.m_en, b1.d_ready, b1.if_ready);
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic gq[$];
    logic g;
    int seen = 0;
    int cyc = 0;
    gq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h3400; b1.d_be = 4'hF;
    b1.if_req = 1; b1.if_addr = 32'h140;
    while (seen < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (b1.d_ready) begin
        vectors++;
        if (b1.d_rdata !== mem_f(32'h3400)) begin
          miscompares++;
          $display("FAIL starve_drdata got=%h want=%h", b1.d_rdata, mem_f(32'h3400));
        end
      end
      if (b1.m_en) begin
        g = gq.pop_front();
        vectors++;
        if ((b1.m_addr == 32'h3400) !== g) begin
          miscompares++;
          $display("FAIL starve_order grant=%0d got data=%b want data=%b", seen, b1.m_addr == 32'h3400, g);
        end
        seen++;
        if (seen == 10) b1.d_req = 0;
      end
    end
    vectors++;
    if (seen != 10) begin
      miscompares++;
      $display("FAIL starve_timeout got grants=%0d want 10", seen);
    end
    cyc = 0;
    while (!b1.if_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (b1.if_ready !== 1'b1 || b1.if_rdata !== mem_f(32'h140)) begin
      miscompares++;
      $display("FAIL starve_fetch got rdy=%b rdata=%h want 1 %h", b1.if_ready, b1.if_rdata, mem_f(32'h140));
    end
    b1.if_req = 0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (b1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_idle got busy=%b want 0", b1.busy);
    end
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    @(negedge clk);
    b4.d_req = 1; b4.d_we = 0; b4.d_addr = 32'h3800; b4.d_be = 4'hF;
    exp_q.push_back('{is_data: 1'b1, addr: 32'h3800, rdata: mem_f(32'h3800)});
    @(negedge clk);
    vectors++;
    if ({b4.m_en, b4.m_addr} !== {1'b1, 32'h3800}) begin
      miscompares++;
      $display("FAIL rstw_issue got en=%b addr=%h want 1 3800", b4.m_en, b4.m_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst4 = 1;
    #1;
    vectors++;
    if ({b4.busy, b4.m_en, b4.d_ready, b4.d_rdata} !== {3'b000, 32'h0}) begin
      miscompares++;
      $display("FAIL rstw_async got busy=%b en=%b rdy=%b rdata=%h want 0 0 0 0",
               b4.busy, b4.m_en, b4.d_ready, b4.d_rdata);
    end
    @(negedge clk);
    vectors++;
    if ({b4.busy, b4.d_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstw_hold got busy=%b rdy=%b want 0 0", b4.busy, b4.d_ready);
    end
    rst4 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      vectors++;
      if ({b4.m_en, b4.d_ready} !== {(k == 1), (k == 6)}) begin
        miscompares++;
        $display("FAIL rstw_reissue k=%0d got en=%b rdy=%b want %b %b",
                 k, b4.m_en, b4.d_ready, (k == 1), (k == 6));
      end
      if (k == 6) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rstw_scoreboard got empty queue want one entry");
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (b4.d_rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rstw_rdata got=%h want=%h", b4.d_rdata, e.rdata);
          end
        end
        b4.d_req = 0;
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    rst1 = 1; rst4 = 1;
    clear_inputs();
    b1.m_rdata = GARB; b4.m_rdata = GARB;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
